// File: rtl/ex_stage_if.sv
// ID/EX operands and controls in, EX/ME pipeline register contents out.
// master drives the stage (ID side / bench), slave is the execute stage.
interface ex_stage_if;
  logic [31:0] EX_ReadData1, EX_ReadData2, EX_SignImm, EX_PCPlus4;
  logic [31:0] EX_FwdME, EX_FwdWB;
  logic [4:0]  EX_Shamt, EX_RegToWrite;
  logic [1:0]  EX_C_FwdA, EX_C_FwdB, EX_C_HiLoRead, EX_C_Jump, EX_C_Extend;
  logic [3:0]  EX_C_ALUOp;
  logic        EX_C_ALUSrc, EX_C_ShiftVar;
  logic        EX_C_RegWrite, EX_C_DataSource, EX_C_MemWrite, EX_C_StoreLoad, EX_C_Halt;
  logic        EX_C_Stall_DB;

  logic [31:0] EX_ALUOut_O, EX_DataToWrite_O, EX_PCPlus4_O;
  logic [4:0]  EX_RegToWrite_O;
  logic        EX_C_RegWrite_O, EX_C_DataSource_O, EX_C_MemWrite_O, EX_C_StoreLoad_O, EX_C_Halt_O;
  logic [1:0]  EX_C_Jump_O, EX_C_Extend_O;
  logic        EX_Busy;

  modport master (
    output EX_ReadData1, EX_ReadData2, EX_SignImm, EX_PCPlus4, EX_FwdME, EX_FwdWB,
           EX_Shamt, EX_RegToWrite, EX_C_FwdA, EX_C_FwdB, EX_C_HiLoRead, EX_C_Jump,
           EX_C_Extend, EX_C_ALUOp, EX_C_ALUSrc, EX_C_ShiftVar, EX_C_RegWrite,
           EX_C_DataSource, EX_C_MemWrite, EX_C_StoreLoad, EX_C_Halt, EX_C_Stall_DB,
    input  EX_ALUOut_O, EX_DataToWrite_O, EX_PCPlus4_O, EX_RegToWrite_O, EX_C_RegWrite_O,
           EX_C_DataSource_O, EX_C_MemWrite_O, EX_C_StoreLoad_O, EX_C_Halt_O,
           EX_C_Jump_O, EX_C_Extend_O, EX_Busy
  );

  modport slave (
    input  EX_ReadData1, EX_ReadData2, EX_SignImm, EX_PCPlus4, EX_FwdME, EX_FwdWB,
           EX_Shamt, EX_RegToWrite, EX_C_FwdA, EX_C_FwdB, EX_C_HiLoRead, EX_C_Jump,
           EX_C_Extend, EX_C_ALUOp, EX_C_ALUSrc, EX_C_ShiftVar, EX_C_RegWrite,
           EX_C_DataSource, EX_C_MemWrite, EX_C_StoreLoad, EX_C_Halt, EX_C_Stall_DB,
    output EX_ALUOut_O, EX_DataToWrite_O, EX_PCPlus4_O, EX_RegToWrite_O, EX_C_RegWrite_O,
           EX_C_DataSource_O, EX_C_MemWrite_O, EX_C_StoreLoad_O, EX_C_Halt_O,
           EX_C_Jump_O, EX_C_Extend_O, EX_Busy
  );
endinterface

// File: rtl/ex_stage.sv
// MIPS execute stage: operand forwarding, single-cycle ALU, iterative mul/div into HI/LO,
// and the EX/ME pipeline register. Emits bubbles while the mul/div unit is busy.
module ex_stage #(
  parameter int MD_STEPS = 32
) (
  input logic       clk,
  input logic       rst_n,
  ex_stage_if.slave bus
);
  localparam int CW = $clog2(MD_STEPS);

  typedef enum logic [1:0] {IDLE, MUL, DIV} md_state_t;

  md_state_t   state;
  logic [CW-1:0] count;
  logic [63:0] acc;
  logic [31:0] opnd, hi, lo;
  logic        neg, sign_a, div0, busy;

  logic [31:0] fwd_a, fwd_b, alu_b, alu_res, result, abs_a, abs_b;
  logic [4:0]  sh;
  logic        md_op, signed_op;
  logic [32:0] mul_sum, div_shift;
  logic [63:0] prod_next, prod_fin;
  logic [31:0] div_sub, rem_next, quo_next;
  logic        div_ge;

  always_comb begin
    unique case (bus.EX_C_FwdA)
      2'b01:   fwd_a = bus.EX_FwdME;
      2'b10:   fwd_a = bus.EX_FwdWB;
      default: fwd_a = bus.EX_ReadData1;
    endcase
    unique case (bus.EX_C_FwdB)
      2'b01:   fwd_b = bus.EX_FwdME;
      2'b10:   fwd_b = bus.EX_FwdWB;
      default: fwd_b = bus.EX_ReadData2;
    endcase
    alu_b = bus.EX_C_ALUSrc ? bus.EX_SignImm : fwd_b;
    sh    = bus.EX_C_ShiftVar ? fwd_a[4:0] : bus.EX_Shamt;

    unique case (bus.EX_C_ALUOp)
      4'h0:    alu_res = fwd_a + alu_b;
      4'h1:    alu_res = fwd_a - alu_b;
      4'h2:    alu_res = fwd_a & alu_b;
      4'h3:    alu_res = fwd_a | alu_b;
      4'h4:    alu_res = fwd_a ^ alu_b;
      4'h5:    alu_res = ~(fwd_a | alu_b);
      4'h6:    alu_res = {31'b0, $signed(fwd_a) < $signed(alu_b)};
      4'h7:    alu_res = {31'b0, fwd_a < alu_b};
      4'h8:    alu_res = alu_b << sh;
      4'h9:    alu_res = alu_b >> sh;
      4'hA:    alu_res = $unsigned($signed(alu_b) >>> sh);
      4'hB:    alu_res = {alu_b[15:0], 16'h0};
      default: alu_res = 32'h0;
    endcase

    unique case (bus.EX_C_HiLoRead)
      2'b01:   result = hi;
      2'b10:   result = lo;
      default: result = alu_res;
    endcase
  end

  // Mul/div operands come from the forwarded register values, never the immediate.
  assign md_op     = (bus.EX_C_ALUOp[3:2] == 2'b11);
  assign signed_op = md_op && !bus.EX_C_ALUOp[0];
  assign abs_a     = (signed_op && fwd_a[31]) ? -fwd_a : fwd_a;
  assign abs_b     = (signed_op && fwd_b[31]) ? -fwd_b : fwd_b;

  // acc holds {partial product, remaining multiplier} for MUL and {remainder, dividend} for DIV.
  always_comb begin
    mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
    prod_next = {mul_sum, acc[31:1]};
    prod_fin  = neg ? -prod_next : prod_next;
    div_shift = {acc[63:32], acc[31]};
    div_ge    = (div_shift >= {1'b0, opnd});
    div_sub   = div_shift[31:0] - opnd;
    rem_next  = div_ge ? div_sub : div_shift[31:0];
    quo_next  = {acc[30:0], div_ge};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      count  <= '0;
      acc    <= 64'h0;
      opnd   <= 32'h0;
      neg    <= 1'b0;
      sign_a <= 1'b0;
      div0   <= 1'b0;
      hi     <= 32'h0;
      lo     <= 32'h0;
      busy   <= 1'b0;
    end else if (!bus.EX_C_Stall_DB) begin
      unique case (state)
        IDLE: if (md_op) begin
          acc    <= {32'h0, abs_a};
          opnd   <= abs_b;
          sign_a <= signed_op && fwd_a[31];
          neg    <= signed_op && (fwd_a[31] ^ fwd_b[31]);
          div0   <= (fwd_b == 32'h0);
          count  <= '0;
          state  <= bus.EX_C_ALUOp[1] ? DIV : MUL;
          busy   <= 1'b1;
        end
        MUL: if (count == CW'(MD_STEPS - 1)) begin
          {hi, lo} <= prod_fin;
          state    <= IDLE;
          busy     <= 1'b0;
        end else begin
          acc   <= prod_next;
          count <= count + 1'b1;
        end
        DIV: if (count == CW'(MD_STEPS - 1)) begin
          lo    <= div0 ? 32'hFFFF_FFFF : (neg ? -quo_next : quo_next);
          hi    <= sign_a ? -rem_next : rem_next;
          state <= IDLE;
          busy  <= 1'b0;
        end else begin
          acc   <= {rem_next, quo_next};
          count <= count + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.EX_Busy = busy;

  // EX/ME register; the issuing mul/div and all busy-cycle slots go down as non-writing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.EX_ALUOut_O       <= 32'h0;
      bus.EX_DataToWrite_O  <= 32'h0;
      bus.EX_PCPlus4_O      <= 32'h0;
      bus.EX_RegToWrite_O   <= 5'h0;
      bus.EX_C_RegWrite_O   <= 1'b0;
      bus.EX_C_DataSource_O <= 1'b0;
      bus.EX_C_MemWrite_O   <= 1'b0;
      bus.EX_C_StoreLoad_O  <= 1'b0;
      bus.EX_C_Halt_O       <= 1'b0;
      bus.EX_C_Jump_O       <= 2'b00;
      bus.EX_C_Extend_O     <= 2'b00;
    end else if (!bus.EX_C_Stall_DB) begin
      if (busy) begin
        bus.EX_ALUOut_O       <= 32'h0;
        bus.EX_DataToWrite_O  <= 32'h0;
        bus.EX_PCPlus4_O      <= 32'h0;
        bus.EX_RegToWrite_O   <= 5'h0;
        bus.EX_C_RegWrite_O   <= 1'b0;
        bus.EX_C_DataSource_O <= 1'b0;
        bus.EX_C_MemWrite_O   <= 1'b0;
        bus.EX_C_StoreLoad_O  <= 1'b0;
        bus.EX_C_Halt_O       <= 1'b0;
        bus.EX_C_Jump_O       <= 2'b00;
        bus.EX_C_Extend_O     <= 2'b00;
      end else begin
        bus.EX_ALUOut_O       <= result;
        bus.EX_DataToWrite_O  <= fwd_b;
        bus.EX_PCPlus4_O      <= bus.EX_PCPlus4;
        bus.EX_RegToWrite_O   <= bus.EX_RegToWrite;
        bus.EX_C_RegWrite_O   <= bus.EX_C_RegWrite && !md_op;
        bus.EX_C_DataSource_O <= bus.EX_C_DataSource;
        bus.EX_C_MemWrite_O   <= bus.EX_C_MemWrite && !md_op;
        bus.EX_C_StoreLoad_O  <= bus.EX_C_StoreLoad;
        bus.EX_C_Halt_O       <= bus.EX_C_Halt;
        bus.EX_C_Jump_O       <= bus.EX_C_Jump;
        bus.EX_C_Extend_O     <= bus.EX_C_Extend;
      end
    end
  end
endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU ops, forwarding, mul/div latency and results, stall, reset.
module tb_ex_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

  ex_stage_if bus ();

  ex_stage #(.MD_STEPS(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    bus.EX_ReadData1 = 0; bus.EX_ReadData2 = 0; bus.EX_SignImm = 0; bus.EX_PCPlus4 = 0;
    bus.EX_FwdME = 0; bus.EX_FwdWB = 0; bus.EX_Shamt = 0; bus.EX_RegToWrite = 0;
    bus.EX_C_FwdA = 0; bus.EX_C_FwdB = 0; bus.EX_C_HiLoRead = 0; bus.EX_C_Jump = 0;
    bus.EX_C_Extend = 0; bus.EX_C_ALUOp = 0; bus.EX_C_ALUSrc = 0; bus.EX_C_ShiftVar = 0;
    bus.EX_C_RegWrite = 0; bus.EX_C_DataSource = 0; bus.EX_C_MemWrite = 0;
    bus.EX_C_StoreLoad = 0; bus.EX_C_Halt = 0; bus.EX_C_Stall_DB = 0;
  endtask

  task automatic drive_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    clear_in();
    bus.EX_C_ALUOp = op; bus.EX_ReadData1 = a; bus.EX_ReadData2 = b; bus.EX_C_RegWrite = 1;
  endtask

  task automatic drive_hilo(input logic [1:0] sel);
    clear_in();
    bus.EX_C_HiLoRead = sel; bus.EX_C_RegWrite = 1; bus.EX_RegToWrite = 5'd9;
  endtask

  // Counts busy samples until EX_Busy drops (bounded); the stall window is given in busy samples.
  task automatic wait_busy(input int stall_at, input int stall_len, output int n);
    n = 0;
    for (int i = 0; i < 80; i++) begin
      if (bus.EX_Busy !== 1'b1) break;
      n++;
      if (n == stall_at) bus.EX_C_Stall_DB = 1;
      if (n == stall_at + stall_len) bus.EX_C_Stall_DB = 0;
      step();
    end
    bus.EX_C_Stall_DB = 0;
  endtask

  task automatic test_reset();
    clear_in();
    rst_n = 0;
    #12;
    checks++;
    if (bus.EX_ALUOut_O !== 32'h0 || bus.EX_C_RegWrite_O !== 1'b0 || bus.EX_Busy !== 1'b0) begin
      errors++;
      $display("FAIL reset: alu=%h rw=%b busy=%b, want 0/0/0", bus.EX_ALUOut_O, bus.EX_C_RegWrite_O, bus.EX_Busy);
    end
    @(negedge clk);
    rst_n = 1;
    step();
  endtask

  task automatic test_alu();
    logic [3:0]  ops [13] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'h8};
    logic [31:0] va  [13] = '{32'h7FFFFFFF, 32'h0, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hFFFF0000, 32'h0,
                              32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h3};
    logic [31:0] vb  [13] = '{32'h1, 32'h1, 32'hFF00FF00, 32'h0F0F0000, 32'h0F0F0F0F, 32'h0,
                              32'h1, 32'h1, 32'h1, 32'h80000000, 32'h80000000, 32'h00001234, 32'h1};
    logic [31:0] ve  [13] = '{32'h80000000, 32'hFFFFFFFF, 32'hF000F000, 32'hFFFFF0F0, 32'hF0F00F0F,
                              32'hFFFFFFFF, 32'h1, 32'h0, 32'h10, 32'h08000000, 32'hF8000000,
                              32'h12340000, 32'h8};
    for (int i = 0; i < 13; i++) begin
      drive_op(ops[i], va[i], vb[i]);
      bus.EX_Shamt = 5'd4;
      bus.EX_C_ShiftVar = (i == 12);
      bus.EX_PCPlus4 = 32'h400 + i;
      bus.EX_RegToWrite = 5'(i + 1);
      step();
      checks++;
      if (bus.EX_ALUOut_O !== ve[i] || bus.EX_C_RegWrite_O !== 1'b1 ||
          bus.EX_PCPlus4_O !== 32'h400 + i || bus.EX_RegToWrite_O !== 5'(i + 1)) begin
        errors++;
        $display("FAIL alu[%0d] op=%h: alu=%h rw=%b pc=%h rd=%0d, want alu=%h rw=1 pc=%h rd=%0d",
                 i, ops[i], bus.EX_ALUOut_O, bus.EX_C_RegWrite_O, bus.EX_PCPlus4_O,
                 bus.EX_RegToWrite_O, ve[i], 32'h400 + i, i + 1);
      end
    end
  endtask

  task automatic test_forward();
    drive_op(4'h0, 32'h0, 32'h55);
    bus.EX_C_FwdA = 2'b01; bus.EX_FwdME = 32'h10;
    bus.EX_C_FwdB = 2'b10; bus.EX_FwdWB = 32'hAB;
    bus.EX_C_ALUSrc = 1; bus.EX_SignImm = 32'h4;
    bus.EX_C_MemWrite = 1; bus.EX_C_Jump = 2'b10; bus.EX_C_Extend = 2'b01;
    step();
    checks++;
    if (bus.EX_ALUOut_O !== 32'h14 || bus.EX_DataToWrite_O !== 32'hAB ||
        bus.EX_C_MemWrite_O !== 1'b1 || bus.EX_C_Jump_O !== 2'b10 || bus.EX_C_Extend_O !== 2'b01) begin
      errors++;
      $display("FAIL forward: alu=%h dtw=%h mw=%b j=%b ext=%b, want 14/ab/1/10/01",
               bus.EX_ALUOut_O, bus.EX_DataToWrite_O, bus.EX_C_MemWrite_O, bus.EX_C_Jump_O, bus.EX_C_Extend_O);
    end
  endtask

  task automatic test_mult();
    int n;
    int bub_bad = 0;
    drive_op(4'hC, 32'hFFFFFFFD, 32'h7);
    step();
    checks++;
    if (bus.EX_C_RegWrite_O !== 1'b0 || bus.EX_Busy !== 1'b1) begin
      errors++;
      $display("FAIL mult_issue: rw=%b busy=%b, want 0/1", bus.EX_C_RegWrite_O, bus.EX_Busy);
    end
    drive_hilo(2'b10);
    n = 0;
    for (int i = 0; i < 80; i++) begin
      if (bus.EX_Busy !== 1'b1) break;
      n++;
      if (bus.EX_C_RegWrite_O !== 1'b0 || bus.EX_ALUOut_O !== 32'h0) bub_bad++;
      step();
    end
    checks++;
    if (bub_bad !== 0) begin
      errors++;
      $display("FAIL mult_bubbles: %0d non-bubble slots while busy, want 0", bub_bad);
    end
    checks++;
    if (n !== 32) begin
      errors++;
      $display("FAIL mult_busy_len: %0d cycles, want 32", n);
    end
    step();
    checks++;
    if (bus.EX_ALUOut_O !== 32'hFFFFFFEB || bus.EX_C_RegWrite_O !== 1'b1) begin
      errors++;
      $display("FAIL mult_lo: alu=%h rw=%b, want ffffffeb/1", bus.EX_ALUOut_O, bus.EX_C_RegWrite_O);
    end
    drive_hilo(2'b01);
    step();
    checks++;
    if (bus.EX_ALUOut_O !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL mult_hi: alu=%h, want ffffffff", bus.EX_ALUOut_O);
    end
  endtask

  task automatic test_div();
    int n;
    logic [3:0]  ops [2] = '{4'hE, 4'hF};
    logic [31:0] va  [2] = '{32'hFFFFFFF9, 32'h7};
    logic [31:0] vb  [2] = '{32'h2, 32'h0};
    logic [31:0] elo [2] = '{32'hFFFFFFFD, 32'hFFFFFFFF};
    logic [31:0] ehi [2] = '{32'hFFFFFFFF, 32'h7};
    for (int i = 0; i < 2; i++) begin
      drive_op(ops[i], va[i], vb[i]);
      step();
      drive_hilo(2'b10);
      wait_busy(0, 0, n);
      checks++;
      if (n !== 32) begin
        errors++;
        $display("FAIL div_busy_len[%0d]: %0d cycles, want 32", i, n);
      end
      step();
      checks++;
      if (bus.EX_ALUOut_O !== elo[i]) begin
        errors++;
        $display("FAIL div_lo[%0d]: alu=%h, want %h", i, bus.EX_ALUOut_O, elo[i]);
      end
      drive_hilo(2'b01);
      step();
      checks++;
      if (bus.EX_ALUOut_O !== ehi[i]) begin
        errors++;
        $display("FAIL div_hi[%0d]: alu=%h, want %h", i, bus.EX_ALUOut_O, ehi[i]);
      end
    end
  endtask

  task automatic test_stall();
    int n;
    drive_op(4'h0, 32'h5, 32'h6);
    step();
    drive_op(4'h0, 32'h1, 32'h1);
    bus.EX_C_Stall_DB = 1;
    step();
    step();
    checks++;
    if (bus.EX_ALUOut_O !== 32'hB) begin
      errors++;
      $display("FAIL stall_hold: alu=%h, want 0000000b", bus.EX_ALUOut_O);
    end
    bus.EX_C_Stall_DB = 0;
    step();
    checks++;
    if (bus.EX_ALUOut_O !== 32'h2) begin
      errors++;
      $display("FAIL stall_release: alu=%h, want 00000002", bus.EX_ALUOut_O);
    end
    drive_op(4'hD, 32'h00010000, 32'h00010001);
    step();
    drive_hilo(2'b10);
    wait_busy(10, 5, n);
    checks++;
    if (n !== 37) begin
      errors++;
      $display("FAIL stall_busy_len: %0d cycles, want 37", n);
    end
    step();
    checks++;
    if (bus.EX_ALUOut_O !== 32'h00010000) begin
      errors++;
      $display("FAIL stall_multu_lo: alu=%h, want 00010000", bus.EX_ALUOut_O);
    end
    drive_hilo(2'b01);
    step();
    checks++;
    if (bus.EX_ALUOut_O !== 32'h1) begin
      errors++;
      $display("FAIL stall_multu_hi: alu=%h, want 00000001", bus.EX_ALUOut_O);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    drive_op(4'hC, 32'h12345, 32'h777);
    step();
    drive_hilo(2'b01);
    for (int i = 0; i < 10; i++) step();
    rst_n = 0;
    #1;
    checks++;
    if (bus.EX_Busy !== 1'b0 || bus.EX_ALUOut_O !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b alu=%h, want 0/0", bus.EX_Busy, bus.EX_ALUOut_O);
    end
    @(negedge clk);
    rst_n = 1;
    step();
    checks++;
    if (bus.EX_ALUOut_O !== 32'h0 || bus.EX_Busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_hi: alu=%h busy=%b, want 0/0", bus.EX_ALUOut_O, bus.EX_Busy);
    end
    drive_op(4'hD, 32'h3, 32'h5);
    step();
    drive_hilo(2'b10);
    wait_busy(0, 0, n);
    step();
    checks++;
    if (bus.EX_ALUOut_O !== 32'd15) begin
      errors++;
      $display("FAIL reset_mid_multu: alu=%h, want 0000000f", bus.EX_ALUOut_O);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_forward();
    test_mult();
    test_div();
    test_stall();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
